h10_io_resp: RTL

- Device-side responder for the H10 CPU peripheral bus (H_DSEL/H_DOPT/H_DREQ/H_DOUT in, H_DRDY/H_DIN out). The CPU is the initiator; this block is the other end.
- Serves the four channels in one-hot bit order:
  - bit0 HTR (tape reader)
  - bit1 TO (typewriter out)
  - bit2 TI (typewriter in)
  - bit3 HTP (tape punch)
- Bridges those channels to byte streams: a reader source, a keyboard source, and typewriter and punch sinks. It replaces the dummy I/O and runs on the 2x CPU clock.

---
 rtl/h10_io_pkg.sv | 26 ++
 rtl/h10_out_chan.sv | 87 ++++++++
 rtl/h10_io_resp.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/h10_io_pkg.sv
// Shared constants and channel state encoding for the H10 peripheral-bus responder.
package h10_io_pkg;

    localparam int CH_HTR = 0;
    localparam int CH_TO  = 1;
    localparam int CH_TI  = 2;
    localparam int CH_HTP = 3;

    // Reader status byte (DSEL=0001, DOPT=1)
    localparam int STAT_DRDY = 0;
    localparam int STAT_EOT  = 1;

    // ST_WAIT doubles as HOLD for the output channels
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SEND,
        ST_WAIT,
        ST_DONE
    } chan_state_t;

    function automatic int unsigned dly_min1(input int unsigned d);
        return (d == 0) ? 1 : d;
    endfunction

endpackage

// File: rtl/h10_out_chan.sv
// Output channel (TO / HTP): latches CPU byte, hands it to a valid/ready sink,
// then emulates device speed before raising DRDY.
module h10_out_chan
    import h10_io_pkg::*;
#(
    parameter int OUT_DLY = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rise,
    input  logic       fall,
    input  logic [7:0] dout,
    output logic       x_valid,
    output logic [7:0] x_data,
    input  logic       x_ready,
    output logic       drdy,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LOAD = CNT_W'(dly_min1(OUT_DLY));
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    chan_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [7:0]       obuf, obuf_n;
    logic             drdy_q, drdy_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            obuf   <= '0;
            drdy_q <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            obuf   <= obuf_n;
            drdy_q <= drdy_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        obuf_n  = obuf;
        drdy_n  = drdy_q;
        if (fall) begin
            state_n = ST_IDLE;
            cnt_n   = '0;
            drdy_n  = 1'b0;
        end else begin
            case (state)
                // A new request while DONE restarts with the fresh byte
                ST_IDLE, ST_DONE: begin
                    if (rise) begin
                        obuf_n  = dout;
                        drdy_n  = 1'b0;
                        state_n = ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (x_ready) begin
                        cnt_n   = LOAD;
                        state_n = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt <= ONE) begin
                        cnt_n   = '0;
                        drdy_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        cnt_n = cnt - ONE;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign x_valid = (state == ST_SEND);
    assign x_data  = obuf;
    assign drdy    = drdy_q;
    assign busy    = (state == ST_SEND) || (state == ST_WAIT);

endmodule

// File: rtl/h10_io_resp.sv
// Device-side responder for the H10 CPU peripheral bus: reader, typewriter
// in/out and punch channels bridged to byte streams.
module h10_io_resp
    import h10_io_pkg::*;
#(
    parameter int RD_DLY  = 4,
    parameter int OUT_DLY = 4,
    parameter int CNT_W   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] H_DSEL,
    input  logic       H_DOPT,
    input  logic [3:0] H_DREQ,
    input  logic [7:0] H_DOUT,
    output logic [3:0] H_DRDY,
    output logic [7:0] H_DIN,
    input  logic       rd_valid,
    input  logic [7:0] rd_data,
    input  logic       rd_eot,
    output logic       rd_ready,
    input  logic       kb_valid,
    input  logic [7:0] kb_data,
    output logic       kb_ready,
    output logic       to_valid,
    output logic [7:0] to_data,
    input  logic       to_ready,
    output logic       pu_valid,
    output logic [7:0] pu_data,
    input  logic       pu_ready
);

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(dly_min1(RD_DLY));
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [3:0] req_q, rise, fall;
    logic       tisel_q;

    chan_state_t      rd_state, rd_state_n;
    logic [CNT_W-1:0] rd_cnt, rd_cnt_n;
    logic [7:0]       rbuf, rbuf_n;
    logic             eot_flag, eot_n;
    logic             drdy0, drdy0_n;

    logic       kfull, ti_consume;
    logic [7:0] kbuf;
    logic [7:0] din_q, din_n;
    logic       drdy1, drdy3, busy1, busy3;
    logic       unused_sig;

    always_ff @(posedge clk) begin
        if (reset) begin
            req_q   <= '0;
            tisel_q <= 1'b0;
        end else begin
            req_q   <= H_DREQ;
            tisel_q <= H_DSEL[CH_TI];
        end
    end

    assign rise = H_DREQ & ~req_q;
    assign fall = ~H_DREQ & req_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state <= ST_IDLE;
            rd_cnt   <= '0;
            rbuf     <= '0;
            eot_flag <= 1'b0;
            drdy0    <= 1'b0;
        end else begin
            rd_state <= rd_state_n;
            rd_cnt   <= rd_cnt_n;
            rbuf     <= rbuf_n;
            eot_flag <= eot_n;
            drdy0    <= drdy0_n;
        end
    end

    always_comb begin
        rd_state_n = rd_state;
        rd_cnt_n   = rd_cnt;
        rbuf_n     = rbuf;
        eot_n      = eot_flag;
        drdy0_n    = drdy0;
        if (fall[CH_HTR]) begin
            // Abort: a byte still in its tape-delay window is thrown away
            rd_state_n = ST_IDLE;
            rd_cnt_n   = '0;
            drdy0_n    = 1'b0;
            if (rd_state == ST_WAIT) rbuf_n = '0;
        end else begin
            case (rd_state)
                ST_IDLE: begin
                    if (rise[CH_HTR]) begin
                        drdy0_n    = 1'b0;
                        rd_state_n = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (rd_valid) begin
                        rbuf_n     = rd_data;
                        rd_cnt_n   = RD_LOAD;
                        rd_state_n = ST_WAIT;
                    end else if (rd_eot) begin
                        eot_n = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (rd_cnt <= ONE) begin
                        rd_cnt_n   = '0;
                        drdy0_n    = 1'b1;
                        rd_state_n = ST_DONE;
                    end else begin
                        rd_cnt_n = rd_cnt - ONE;
                    end
                end
                ST_DONE: ;
                default: rd_state_n = ST_IDLE;
            endcase
        end
    end

    assign rd_ready = (rd_state == ST_FETCH);

    // Keyboard byte is consumed when the CPU deselects TI after a data read
    assign ti_consume = tisel_q & ~H_DSEL[CH_TI] & ~H_DOPT;

    always_ff @(posedge clk) begin
        if (reset) begin
            kfull <= 1'b0;
            kbuf  <= '0;
        end else if (kfull) begin
            if (ti_consume) kfull <= 1'b0;
        end else if (kb_valid) begin
            kbuf  <= kb_data;
            kfull <= 1'b1;
        end
    end

    assign kb_ready = ~kfull & ~reset;

    h10_out_chan #(.OUT_DLY(OUT_DLY), .CNT_W(CNT_W)) u_to (
        .clk     (clk),
        .reset   (reset),
        .rise    (rise[CH_TO]),
        .fall    (fall[CH_TO]),
        .dout    (H_DOUT),
        .x_valid (to_valid),
        .x_data  (to_data),
        .x_ready (to_ready),
        .drdy    (drdy1),
        .busy    (busy1)
    );

    h10_out_chan #(.OUT_DLY(OUT_DLY), .CNT_W(CNT_W)) u_htp (
        .clk     (clk),
        .reset   (reset),
        .rise    (rise[CH_HTP]),
        .fall    (fall[CH_HTP]),
        .dout    (H_DOUT),
        .x_valid (pu_valid),
        .x_data  (pu_data),
        .x_ready (pu_ready),
        .drdy    (drdy3),
        .busy    (busy3)
    );

    assign unused_sig = ^{rise[CH_TI], fall[CH_TI], busy3};

    always_comb begin
        din_n = 8'h00;
        case (H_DSEL)
            4'b0001: begin
                if (H_DOPT) begin
                    din_n[STAT_DRDY] = drdy0;
                    din_n[STAT_EOT]  = eot_flag;
                end else begin
                    din_n = rbuf;
                end
            end
            4'b0010: if (H_DOPT) din_n = {7'b0, ~busy1};
            4'b0100: din_n = kbuf;
            default: din_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) din_q <= '0;
        else       din_q <= din_n;
    end

    assign H_DIN  = din_q;
    assign H_DRDY = {drdy3, kfull, drdy1, drdy0};

endmodule
